// File: rtl/uart_pkg.sv
// Shared UART constants and the receive-capture state encoding.
package uart_pkg;

    localparam int UART_DATA_W        = 8;
    localparam int UART_RX_FIFO_DEPTH = 16;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_LOW = 1'b1
    } cap_state_t;

endpackage

// File: rtl/fifo_ram.sv
// DEPTH x DATA_W register array: one synchronous write port, one asynchronous read port.
module fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage is intentionally not reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive FIFO: captures each receiver byte once, buffers it first-word-fall-through.
// Optional sticky overflow tracking is enabled with `define UART_RX_FIFO_OVF_EN.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = UART_RX_FIFO_DEPTH,
    parameter int DATA_W = UART_DATA_W
) (
    input  logic                     clk_50m,
    input  logic                     rst_n,
    input  logic                     rx_rdy,
    input  logic [DATA_W-1:0]        rx_data,
    output logic                     rx_rdy_clr,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    cap_state_t        r_state;
    logic              r_rx_rdy_clr;
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic              w_push_req;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_rd_data;

    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_push_req = (r_state == IDLE) && rx_rdy;
    assign w_pop      = rd_en && !w_empty;
    // A pop on the same edge frees a slot, so a full FIFO can still accept the byte.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && w_full && !w_pop;

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_rx_rdy_clr <= 1'b0;
        end else begin
            r_rx_rdy_clr <= w_push_req;
            case (r_state)
                IDLE:     if (rx_rdy)  r_state <= WAIT_LOW;
                WAIT_LOW: if (!rx_rdy) r_state <= IDLE;
                default:               r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef UART_RX_FIFO_OVF_EN
    logic r_overflow;

    // A drop on the same edge as ovf_clr keeps the flag set so no loss goes unreported.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

    assign overflow = r_overflow;
`else
    logic w_unused_ovf;

    assign w_unused_ovf = ovf_clr ^ w_drop;
    assign overflow     = 1'b0;
`endif

    fifo_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (AW)
    ) u_fifo_ram (
        .i_clk     (clk_50m),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (rx_data),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    assign rx_rdy_clr = r_rx_rdy_clr;
    assign rd_data    = w_rd_data;
    assign empty      = w_empty;
    assign full       = w_full;
    assign count      = r_count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: stimulus queues expected bytes, a monitor checks each pop.
module tb_uart_rx_fifo;

    localparam int DEPTH  = 16;
    localparam int DATA_W = 8;

    logic              clk_50m = 1'b0;
    logic              rst_n;
    logic              rx_rdy;
    logic [DATA_W-1:0] rx_data;
    logic              rx_rdy_clr;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              empty;
    logic              full;
    logic [4:0]        count;
    logic              overflow;
    logic              ovf_clr;

    int nChecks = 0;
    int nPass   = 0;
    int mCount  = 0;
    int mOvf    = 0;
    int expPulses = 0;
    int seenPulses = 0;
    logic [DATA_W-1:0] expQ[$];

    uart_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk_50m    (clk_50m),
        .rst_n      (rst_n),
        .rx_rdy     (rx_rdy),
        .rx_data    (rx_data),
        .rx_rdy_clr (rx_rdy_clr),
        .rd_en      (rd_en),
        .rd_data    (rd_data),
        .empty      (empty),
        .full       (full),
        .count      (count),
        .overflow   (overflow),
        .ovf_clr    (ovf_clr)
    );

    always #5 clk_50m = ~clk_50m;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual == expected) nPass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor: a pop is presented whenever rd_en is asserted on a non-empty FIFO.
    always @(negedge clk_50m) begin
        #1;
        if (rd_en && !empty) begin
            nChecks++;
            if (expQ.size() == 0) begin
                $display("[TB] FAIL pop_data: got %0h, expected nothing queued", rd_data);
            end else begin
                logic [DATA_W-1:0] e;
                e = expQ.pop_front();
                if (rd_data == e) nPass++;
                else $display("[TB] FAIL pop_data: got %0h, expected %0h", rd_data, e);
            end
        end
    end

    always @(posedge clk_50m) begin
        #1;
        if (rx_rdy_clr) seenPulses++;
    end

    task automatic checkFlags(input string tag);
        checkOutput({tag, "_count"}, int'(count), mCount);
        checkOutput({tag, "_empty"}, int'(empty), int'(mCount == 0));
        checkOutput({tag, "_full"},  int'(full),  int'(mCount == DEPTH));
    endtask

    // One receiver handshake; optionally a pop and/or ovf_clr on the capture edge.
    task automatic applyStimulus(input logic [DATA_W-1:0] b, input bit withPop, input bit withOvfClr);
        bit willPop;
        bit drop;
        willPop = withPop && (mCount > 0);
        drop    = (mCount == DEPTH) && !willPop;
        rx_rdy  = 1'b1;
        rx_data = b;
        rd_en   = withPop;
        ovf_clr = withOvfClr;
        if (!drop) expQ.push_back(b);
        if (willPop) mCount--;
        if (!drop) mCount++;
`ifdef UART_RX_FIFO_OVF_EN
        if (drop) mOvf = 1;
        else if (withOvfClr) mOvf = 0;
`endif
        expPulses++;
        @(negedge clk_50m);
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        checkOutput("rx_rdy_clr_pulse", int'(rx_rdy_clr), 1);
        rx_rdy = 1'b0;
        @(negedge clk_50m);
        checkOutput("rx_rdy_clr_low", int'(rx_rdy_clr), 0);
    endtask

    task automatic popOne();
        rd_en = 1'b1;
        if (mCount > 0) mCount--;
        @(negedge clk_50m);
        rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        rx_rdy  = 1'b0;
        rx_data = '0;
        rd_en   = 1'b0;
        ovf_clr = 1'b0;
        repeat (3) @(negedge clk_50m);
        checkFlags("reset");
        checkOutput("reset_clr", int'(rx_rdy_clr), 0);
        checkOutput("reset_ovf", int'(overflow), 0);
        rst_n = 1'b1;
        @(negedge clk_50m);

        // Single byte held high for four cycles must be captured exactly once.
        rx_rdy  = 1'b1;
        rx_data = 8'hA5;
        expQ.push_back(8'hA5);
        mCount = 1;
        expPulses++;
        repeat (4) @(negedge clk_50m);
        rx_rdy = 1'b0;
        @(negedge clk_50m);
        checkOutput("single_pulses", seenPulses, expPulses);
        checkFlags("single");
        checkOutput("single_head", int'(rd_data), 8'hA5);
        popOne();
        checkFlags("single_pop");

        // Fill, partial drain, refill across the wrap point, full drain.
        for (int i = 0; i < 16; i++) begin
            applyStimulus(8'(i), 1'b0, 1'b0);
            checkFlags("fill");
        end
        for (int i = 0; i < 8; i++) popOne();
        checkFlags("half");
        for (int i = 16; i < 24; i++) begin
            applyStimulus(8'(i), 1'b0, 1'b0);
            checkFlags("wrap");
        end
        for (int i = 0; i < 16; i++) popOne();
        checkFlags("drained");

        // Overflow: 17th byte dropped, then clear; a drop racing ovf_clr keeps the flag.
        for (int i = 0; i < 16; i++) applyStimulus(8'h20 + 8'(i), 1'b0, 1'b0);
        applyStimulus(8'hEE, 1'b0, 1'b0);
        checkFlags("ovf");
        checkOutput("ovf_set", int'(overflow), mOvf);
        ovf_clr = 1'b1;
        mOvf = 0;
        @(negedge clk_50m);
        ovf_clr = 1'b0;
        checkOutput("ovf_cleared", int'(overflow), 0);
        applyStimulus(8'hEF, 1'b0, 1'b1);
        checkOutput("ovf_set_wins", int'(overflow), mOvf);
        checkFlags("ovf2");

        // Push and pop together at full: oldest byte leaves, new byte joins the tail.
        applyStimulus(8'h55, 1'b1, 1'b0);
        checkFlags("pushpop_full");
        for (int i = 0; i < 16; i++) popOne();
        checkFlags("pushpop_drained");

        // Pop on empty is ignored; the next byte must still come out correctly.
        popOne();
        checkFlags("empty_pop");
        applyStimulus(8'h3C, 1'b0, 1'b0);
        checkOutput("after_empty_pop_head", int'(rd_data), 8'h3C);
        popOne();

        // Asynchronous reset with five stored bytes while a new byte is pending.
        for (int i = 0; i < 5; i++) applyStimulus(8'h60 + 8'(i), 1'b0, 1'b0);
        checkFlags("pre_reset");
        rx_rdy  = 1'b1;
        rx_data = 8'h77;
        #2;
        rst_n = 1'b0;
        expQ.delete();
        mCount = 0;
        mOvf = 0;
        #1;
        checkFlags("async_reset");
        checkOutput("async_reset_clr", int'(rx_rdy_clr), 0);
        checkOutput("async_reset_ovf", int'(overflow), 0);
        @(negedge clk_50m);
        rst_n = 1'b1;
        expQ.push_back(8'h77);
        mCount = 1;
        expPulses++;
        @(negedge clk_50m);
        checkOutput("post_reset_capture", int'(rx_rdy_clr), 1);
        rx_rdy = 1'b0;
        @(negedge clk_50m);
        checkFlags("post_reset");
        popOne();
        checkFlags("final");

        checkOutput("total_pulses", seenPulses, expPulses);
        checkOutput("scoreboard_left", expQ.size(), 0);
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 2..256).
REQ-002 SHALL have parameter DATA_W, default 8, byte width matching the UART receiver data bus.
REQ-003 SHALL have port clk_50m  input  1  sole clock, all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port rx_rdy  input  1  receiver byte-ready flag, held high until cleared.
REQ-006 SHALL have port rx_data  input  DATA_W  receiver byte, stable while rx_rdy high.
REQ-007 SHALL have port rx_rdy_clr  output  1  one-cycle clear pulse to the receiver.
REQ-008 SHALL have port rd_en  input  1  pop request from the consumer.
REQ-009 SHALL have port rd_data  output  DATA_W  head-of-FIFO byte, first-word-fall-through.
REQ-010 SHALL have port empty  output  1  no entries stored.
REQ-011 SHALL have port full  output  1  DEPTH entries stored.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored entries.
REQ-013 SHALL have port overflow  output  1  sticky dropped-byte flag (see REQ-030).
REQ-014 SHALL have port ovf_clr  input  1  synchronous clear of overflow.

Function
REQ-015 Capture FSM SHALL have states IDLE and WAIT_LOW.
REQ-016 In IDLE with rx_rdy=1, the FSM SHALL push rx_data if not full, pulse rx_rdy_clr high for exactly that one cycle, and go to WAIT_LOW.
REQ-017 In WAIT_LOW, rx_rdy_clr SHALL be 0, and the FSM SHALL return to IDLE on the first cycle rx_rdy=0; a byte SHALL never be captured twice.
REQ-018 Push SHALL be visible on count, empty and rd_data the cycle after the capture edge (latency 1).
REQ-019 rd_data SHALL equal the oldest entry whenever empty=0; its value when empty=1 is don't-care.
REQ-020 rd_en=1 with empty=0 SHALL pop one entry on that edge; rd_en with empty=1 SHALL be ignored, with no pointer or count change.
REQ-021 Simultaneous push and pop SHALL both occur with count unchanged, including when full=1.
REQ-022 Push with full=1 and no simultaneous pop SHALL drop the byte and still pulse rx_rdy_clr.
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; full/empty SHALL be derived from count, which is always 0..DEPTH.
REQ-024 full SHALL be high exactly when count==DEPTH; empty SHALL be high exactly when count==0.
REQ-025 ovf_clr and a concurrent drop in the same cycle SHALL leave overflow=1 (set wins).

Reset
REQ-026 rst_n=0 SHALL asynchronously force FSM=IDLE, pointers=0, count=0, empty=1, full=0, rx_rdy_clr=0, overflow=0.
REQ-027 Reset mid-operation SHALL discard all stored bytes; if rx_rdy is still high after release, that byte SHALL be captured as new.
REQ-028 Storage array contents SHALL not be reset.

Configuration
REQ-029 Macro UART_RX_FIFO_OVF_EN SHALL select overflow tracking.
REQ-030 With UART_RX_FIFO_OVF_EN defined, overflow SHALL set on any dropped byte and hold until ovf_clr=1.
REQ-031 Without UART_RX_FIFO_OVF_EN, overflow SHALL be tied 0, ovf_clr ignored, and drops SHALL be silent.

Structure
REQ-032 Shared package uart_pkg SHALL hold the UART_DATA_W=8 constant, UART_RX_FIFO_DEPTH=16 default, and the capture-state enum (IDLE, WAIT_LOW).
REQ-033 Storage SHALL be a sub-module fifo_ram: DEPTH x DATA_W register array, one write port, one asynchronous read port.
REQ-034 The FSM, pointers, count and flags SHALL live in uart_rx_fifo.

Verification
REQ-035 Single byte: rx_rdy high with rx_data=8'hA5 held 4 cycles -> exactly one rx_rdy_clr pulse, count=1, rd_data=8'hA5; rd_en -> empty=1.
REQ-036 Fill and wrap: push 8'h00..8'h0F, pop 8, push 8'h10..8'h17, pop 16 -> output sequence 8'h00..8'h17 in order, full seen only at count=16.
REQ-037 Overflow: 17 pushes with no pops -> 17th byte dropped, rx_rdy_clr still pulses, overflow=1 (OVF_EN) or 0 (not defined), count=16; ovf_clr -> overflow=0.
REQ-038 Simultaneous push/pop at full -> count stays 16, popped byte is the oldest, new byte is at the tail.
REQ-039 Empty pop and reset: rd_en on empty -> no change; rst_n low with count=5 -> count=0, empty=1 immediately, before the next clk_50m edge.
